secded_decoder_engine: RTL and testbench

//  Program-2 counterpart to the program-1 parity encoder: decodes and corrects Hamming(16,11) SECDED words.
//  - Reads NUM_WORDS encoded words from data memory (lo byte at IN_BASE+2i, hi byte at IN_BASE+2i+1).
//  - Corrects single-bit errors and flags double-bit errors.
//  - Writes each recovered 11-bit message plus a 2-bit flag back to data memory.
//  - Sits beside dm1 as a memory master; done handshake matches top_level (reset starts, done acks).

---
 rtl/secded_pkg.sv | 46 ++++
 rtl/secded_decoder_engine_if.sv | 13 +
 rtl/secded_syndrome.sv | 30 +++
 rtl/secded_decoder_engine.sv | 152 +++++++++++++++
 tb/tb_secded_decoder_engine.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/secded_pkg.sv
// Shared types and constants for the Hamming(16,11) SECDED decoder engine.
package secded_pkg;

  localparam int unsigned AW            = 8;
  localparam int unsigned CW_W          = 16;
  localparam int unsigned MSG_W         = 11;
  localparam int unsigned SYN_W         = 4;
  localparam int unsigned CNT_W         = 4;
  localparam int unsigned DEF_NUM_WORDS = 15;
  localparam int unsigned DEF_IN_BASE   = 30;
  localparam int unsigned DEF_OUT_BASE  = 0;
  localparam int unsigned IDX_W         = $clog2(DEF_NUM_WORDS + 1);

  // Parity positions inside the 16-bit codeword; all other bits carry data.
  localparam int unsigned P0_POS = 0;
  localparam int unsigned P1_POS = 1;
  localparam int unsigned P2_POS = 2;
  localparam int unsigned P4_POS = 4;
  localparam int unsigned P8_POS = 8;

  // Data bit placement: d1 at bit 3, d4:d2 at bits 7:5, d11:d5 at bits 15:9.
  localparam int unsigned D1_POS  = 3;
  localparam int unsigned D2_POS  = 5;
  localparam int unsigned D5_POS  = 9;

  typedef enum logic [1:0] {
    FLG_OK  = 2'b00,
    FLG_FIX = 2'b01,
    FLG_DBL = 2'b10
  } flag_t;

  typedef enum logic [2:0] {
    RD_LO  = 3'd0,
    RD_HI  = 3'd1,
    DECODE = 3'd2,
    WR_LO  = 3'd3,
    WR_HI  = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [MSG_W-1:0] data;
    flag_t            flag;
  } dec_t;

endpackage

// File: rtl/secded_decoder_engine_if.sv
// Byte-wide data-memory port: the engine is the master, dm1 the slave.
interface secded_decoder_engine_if;
  import secded_pkg::*;

  logic [AW-1:0] dm_addr;
  logic          dm_wr_en;
  logic [7:0]    dm_wr_data;
  logic [7:0]    dm_rd_data;

  modport master (output dm_addr, output dm_wr_en, output dm_wr_data, input dm_rd_data);
  modport slave  (input dm_addr, input dm_wr_en, input dm_wr_data, output dm_rd_data);

endinterface

// File: rtl/secded_syndrome.sv
// Combinational SECDED check of one codeword: syndrome, overall parity,
// single-bit correction and status flag.
module secded_syndrome
  import secded_pkg::*;
(
  input  logic [CW_W-1:0]  word_i,
  output logic [SYN_W-1:0] s_o,
  output logic             p_o,
  output logic [CW_W-1:0]  corrected_o,
  output flag_t            flag_o
);

  always_comb begin
    s_o         = '0;
    p_o         = ^word_i;
    corrected_o = word_i;
    flag_o      = FLG_OK;
    for (int k = 1; k < int'(CW_W); k++) begin
      if (word_i[k]) s_o = s_o ^ SYN_W'(k);
    end
    // Odd overall parity means one flipped bit; syndrome 0 points at p0.
    if (p_o) begin
      corrected_o[s_o] = ~word_i[s_o];
      flag_o           = FLG_FIX;
    end else if (s_o != '0) begin
      flag_o = FLG_DBL;
    end
  end

endmodule

// File: rtl/secded_decoder_engine.sv
// Memory-mastering decoder: reads encoded words, corrects/flags them and
// writes back message plus flag, five cycles per word.
module secded_decoder_engine
  import secded_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned IN_BASE   = DEF_IN_BASE,
  parameter int unsigned OUT_BASE  = DEF_OUT_BASE
) (
  input  logic                           clk,
  input  logic                           reset,
  secded_decoder_engine_if.master        dm,
  output logic                           done,
  output logic [CNT_W-1:0]               n_single,
  output logic [CNT_W-1:0]               n_double
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        hi_q, hi_d;
  dec_t              dec_q, dec_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  n_single_q, n_single_d;
  logic [CNT_W-1:0]  n_double_q, n_double_d;

  logic [CW_W-1:0]   word_c;
  logic [SYN_W-1:0]  syn_c;
  logic              par_c;
  logic [CW_W-1:0]   corr_c;
  flag_t             flag_c;
  logic [MSG_W-1:0]  msg_c;
  logic [IDX_W-1:0]  idx_inc_c;
  logic [AW-1:0]     in_addr_c;
  logic [AW-1:0]     in_next_c;
  logic [AW-1:0]     out_addr_c;
  logic              unused_bits;

  assign word_c = {hi_q, lo_q};

  secded_syndrome u_syndrome (
    .word_i      (word_c),
    .s_o         (syn_c),
    .p_o         (par_c),
    .corrected_o (corr_c),
    .flag_o      (flag_c)
  );

  assign msg_c       = {corr_c[CW_W-1:D5_POS], corr_c[P8_POS-1:D2_POS], corr_c[D1_POS]};
  assign unused_bits = ^{syn_c, par_c, corr_c[P8_POS], corr_c[P4_POS],
                         corr_c[P2_POS], corr_c[P1_POS], corr_c[P0_POS]};

  assign idx_inc_c  = idx_q + IDX_W'(1);
  assign in_addr_c  = AW'(IN_BASE)  + AW'({idx_q, 1'b0});
  assign in_next_c  = AW'(IN_BASE)  + AW'({idx_inc_c, 1'b0});
  assign out_addr_c = AW'(OUT_BASE) + AW'({idx_q, 1'b0});

  // Address/strobe are registered, so each state sets up the bus for the next one.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    dec_d      = dec_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    n_single_d = n_single_q;
    n_double_d = n_double_q;
    case (state_q)
      RD_LO: begin
        lo_d    = dm.dm_rd_data;
        addr_d  = in_addr_c + AW'(1);
        state_d = RD_HI;
      end
      RD_HI: begin
        hi_d    = dm.dm_rd_data;
        addr_d  = out_addr_c;
        state_d = DECODE;
      end
      DECODE: begin
        dec_d     = '{data: msg_c, flag: flag_c};
        addr_d    = out_addr_c;
        wr_en_d   = 1'b1;
        wr_data_d = msg_c[7:0];
        if (flag_c == FLG_FIX && n_single_q != '1) n_single_d = n_single_q + CNT_W'(1);
        if (flag_c == FLG_DBL && n_double_q != '1) n_double_d = n_double_q + CNT_W'(1);
        state_d   = WR_LO;
      end
      WR_LO: begin
        addr_d    = out_addr_c + AW'(1);
        wr_en_d   = 1'b1;
        wr_data_d = {dec_q.flag, 3'b000, dec_q.data[MSG_W-1:8]};
        state_d   = WR_HI;
      end
      WR_HI: begin
        idx_d = idx_inc_c;
        if (idx_inc_c < IDX_W'(NUM_WORDS)) begin
          addr_d  = in_next_c;
          state_d = RD_LO;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: state_d = RD_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RD_LO;
      idx_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      dec_q      <= '{data: '0, flag: FLG_OK};
      addr_q     <= AW'(IN_BASE);
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      n_single_q <= '0;
      n_double_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      dec_q      <= dec_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      n_single_q <= n_single_d;
      n_double_q <= n_double_d;
    end
  end

  assign dm.dm_addr    = addr_q;
  assign dm.dm_wr_en   = wr_en_q;
  assign dm.dm_wr_data = wr_data_q;
  assign done          = done_q;
  assign n_single      = n_single_q;
  assign n_double      = n_double_q;

endmodule

// File: tb/tb_secded_decoder_engine.sv
// Bench for secded_decoder_engine: behavioural dm1, write scoreboard, directed
// vectors, reset-abort sequence and randomly corrupted encoded words.
module tb_secded_decoder_engine;
  import secded_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done;
  logic [3:0] n_single;
  logic [3:0] n_double;

  always #5 clk = ~clk;

  secded_decoder_engine_if dm_if ();

  secded_decoder_engine dut (
    .clk      (clk),
    .reset    (reset),
    .dm       (dm_if.master),
    .done     (done),
    .n_single (n_single),
    .n_double (n_double)
  );

  logic [7:0] mem [256];
  assign dm_if.dm_rd_data = mem[dm_if.dm_addr];
  always @(posedge clk) if (dm_if.dm_wr_en) mem[dm_if.dm_addr] <= dm_if.dm_wr_data;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t sb_q[$];
  bit  sb_en = 1'b0;

  logic [15:0] words [15];
  logic [3:0]  e_single, e_double;

  typedef struct {
    logic [15:0] w0;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
    logic [3:0]  es;
    logic [3:0]  ed;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected (addr,data).
  always @(negedge clk) begin
    if (sb_en && dm_if.dm_wr_en) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_write: unexpected write addr=%0h data=%0h", dm_if.dm_addr, dm_if.dm_wr_data);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        if (e.addr !== dm_if.dm_addr || e.data !== dm_if.dm_wr_data) begin
          failures++;
          $display("FAIL sb_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   dm_if.dm_addr, dm_if.dm_wr_data, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [10:0] extract(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] w;
    w = '0;
    w[3] = m[0];
    w[7:5] = m[3:1];
    w[15:9] = m[10:4];
    for (int p = 1; p <= 8; p = p * 2) begin
      logic par;
      par = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & p) != 0 && k != p) par ^= w[k];
      w[p] = par;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic bit is_codeword(input logic [15:0] w);
    logic [3:0] s;
    s = '0;
    for (int k = 1; k < 16; k++) if (w[k]) s ^= 4'(k);
    return (s == 4'd0) && ((^w) == 1'b0);
  endfunction

  // Reference decode by search: clean, one flip away from a codeword, or neither.
  function automatic logic [12:0] ref_decode(input logic [15:0] w);
    logic [15:0] t;
    if (is_codeword(w)) return {2'b00, extract(w)};
    for (int b = 0; b < 16; b++) begin
      t = w ^ (16'h1 << b);
      if (is_codeword(t)) return {2'b01, extract(t)};
    end
    return {2'b10, extract(w)};
  endfunction

  task automatic prepare();
    logic [12:0] r;
    logic [7:0]  lo, hi;
    sb_q.delete();
    e_single = '0;
    e_double = '0;
    for (int i = 0; i < 15; i++) begin
      mem[DEF_IN_BASE + 2*i]     = words[i][7:0];
      mem[DEF_IN_BASE + 2*i + 1] = words[i][15:8];
      mem[2*i]     = 8'hAA;
      mem[2*i + 1] = 8'hAA;
      r  = ref_decode(words[i]);
      lo = r[7:0];
      hi = {r[12:11], 3'b000, r[10:8]};
      sb_q.push_back('{addr: 8'(2*i), data: lo});
      sb_q.push_back('{addr: 8'(2*i + 1), data: hi});
      if (r[12:11] == 2'b01 && e_single != 4'hF) e_single++;
      if (r[12:11] == 2'b10 && e_double != 4'hF) e_double++;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_done_latency"}, 32'(cyc), 32'd75);
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_end(input string name);
    chk({name, "_n_single"}, 32'(n_single), 32'(e_single));
    chk({name, "_n_double"}, 32'(n_double), 32'(e_double));
    chk({name, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(dm_if.dm_addr), 32'd30);
    chk("rst_wr_en", 32'(dm_if.dm_wr_en), 32'd0);
    chk("rst_wr_data", 32'(dm_if.dm_wr_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_counters", 32'({n_single, n_double}), 32'd0);

    // Directed single-word vectors (other words clean zeros)
    vecs[0] = '{w0: 16'hFFFF, exp_lo: 8'hFF, exp_hi: 8'h07, es: 4'd0, ed: 4'd0};
    vecs[1] = '{w0: 16'hFFDF, exp_lo: 8'hFF, exp_hi: 8'h47, es: 4'd1, ed: 4'd0};
    vecs[2] = '{w0: 16'hFFFE, exp_lo: 8'hFF, exp_hi: 8'h47, es: 4'd1, ed: 4'd0};
    vecs[3] = '{w0: 16'hFDDF, exp_lo: 8'hED, exp_hi: 8'h87, es: 4'd0, ed: 4'd1};
    for (int v = 0; v < 4; v++) begin
      words[0] = vecs[v].w0;
      for (int i = 1; i < 15; i++) words[i] = 16'h0000;
      prepare();
      sb_en = 1'b1;
      pulse_reset();
      wait_done($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_dm0", v), 32'(mem[0]), 32'(vecs[v].exp_lo));
      chk($sformatf("vec%0d_dm1", v), 32'(mem[1]), 32'(vecs[v].exp_hi));
      chk($sformatf("vec%0d_n_single", v), 32'(n_single), 32'(vecs[v].es));
      chk($sformatf("vec%0d_n_double", v), 32'(n_double), 32'(vecs[v].ed));
      check_end($sformatf("vec%0d", v));
    end

    // All-zero words
    begin
      int nz;
      for (int i = 0; i < 15; i++) words[i] = 16'h0000;
      prepare();
      pulse_reset();
      wait_done("zeros");
      nz = 0;
      for (int a = 0; a < 30; a++) if (mem[a] != 8'h00) nz++;
      chk("zeros_out_nonzero_bytes", 32'(nz), 32'd0);
      check_end("zeros");
    end

    // Reset mid-run at cycle 20, then full restart
    for (int i = 0; i < 15; i++) words[i] = encode(11'(i * 97 + 5)) ^ (16'h1 << (i % 16));
    prepare();
    sb_en = 1'b0;
    pulse_reset();
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_counters", 32'({n_single, n_double}), 32'd0);
    chk("abort_addr", 32'(dm_if.dm_addr), 32'd30);
    chk("abort_wr_en", 32'(dm_if.dm_wr_en), 32'd0);
    prepare();
    sb_en = 1'b1;
    reset = 1'b0;
    wait_done("restart");
    check_end("restart");

    // Random encoded words with 0, 1 or 2 flipped bits
    for (int r = 0; r < 3; r++) begin
      int bad;
      for (int i = 0; i < 15; i++) begin
        int nf, b1, b2;
        logic [15:0] w;
        w  = encode(11'($urandom_range(2047, 0)));
        nf = $urandom_range(2, 0);
        b1 = $urandom_range(15, 0);
        b2 = (b1 + $urandom_range(15, 1)) % 16;
        if (nf >= 1) w[b1] = ~w[b1];
        if (nf == 2) w[b2] = ~w[b2];
        words[i] = w;
      end
      prepare();
      pulse_reset();
      wait_done($sformatf("rand%0d", r));
      bad = 0;
      for (int i = 0; i < 15; i++) begin
        logic [12:0] rd;
        rd = ref_decode(words[i]);
        if (mem[2*i] != rd[7:0] || mem[2*i+1] != {rd[12:11], 3'b000, rd[10:8]}) bad++;
      end
      chk($sformatf("rand%0d_mem_words_wrong", r), 32'(bad), 32'd0);
      check_end($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
